mips_regfile_dbg: RTL and testbench
===================================

Name: mips_regfile_dbg

Overview:
Parametrised successor to the ID-stage register file of the MIPS pipeline.
- Configurable width, depth and number of read ports.
- Optional write-to-read bypass.
- Built-in debug dump engine: streams a chosen register range over a valid/ready handshake, so benches and the future debug unit can inspect architectural state without hierarchical peeking.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of registers (power of two, >=2)
ADDR_W, $clog2(NREGS), register index width
NRD, 2, number of combinational read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
ClockIn  in  1  single clock, rising-edge
Reset  in  1  asynchronous, active-low reset
RdAddr  in  NRD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
RdData  out  NRD*DATA_W  packed read data
WrEn  in  1  write enable
WrAddr  in  ADDR_W  write index
WrData  in  DATA_W  write data
DumpStart  in  1  request dump (sampled only in IDLE)
DumpLo  in  ADDR_W  first index to dump
DumpHi  in  ADDR_W  last index to dump
DumpBusy  out  1  engine active
DumpValid  out  1  beat valid
DumpReady  in  1  sink accepts beat
DumpAddr  out  ADDR_W  index of current beat
DumpData  out  DATA_W  value of current beat
DumpLast  out  1  current beat is DumpHi
DumpErr  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset (async, Reset=0):
  - All registers cleared to 0.
  - FSM returns to IDLE.
  - DumpBusy, DumpValid, DumpLast, DumpErr = 0; DumpAddr, DumpData = 0.
  - Takes effect immediately, including mid-dump; the partial dump is abandoned with no final beat.
- Register 0:
  - Reads always return 0.
  - Writes to index 0 are discarded, including via bypass.
- Write: on rising edge when WrEn=1 and WrAddr!=0.
- Read: combinational. If BYPASS=1, WrEn=1 and RdAddr_i==WrAddr!=0, RdData_i=WrData; otherwise stored value. All NRD ports are independent; duplicate addresses are allowed.
- FSM states: IDLE, SEND.
- IDLE:
  - DumpStart=1 with DumpLo<=DumpHi -> capture Lo/Hi, enter SEND; DumpBusy=1 and DumpValid=1 on the next cycle (1-cycle latency).
  - First beat: DumpAddr=Lo, DumpData = register value as visible at the capturing edge (bypassed if that edge writes Lo).
  - DumpStart=1 with DumpLo>DumpHi -> stay IDLE; DumpErr=1 for exactly one cycle.
- SEND:
  - DumpValid held high. DumpAddr/DumpData/DumpLast are registered and stay stable while DumpReady=0, even if the presented register is written meanwhile.
  - Handshake (Valid&Ready) on a non-last beat: DumpAddr increments; next beat presented on the following cycle with no bubble (1 beat/cycle throughput). Data again captured with bypass semantics.
  - Handshake on DumpLast=1: next cycle IDLE, DumpValid=0, DumpBusy=0.
- DumpStart in SEND is ignored, with no error.
- Writes during a dump are legal. Registers not yet presented reflect writes made before their beat loads.
- DumpLo==DumpHi: single beat, DumpLast=1.
- DumpHi=NREGS-1: index never wraps; the FSM terminates on Last.

Decomposition:
- Shared package mips_pkg: DATA_W/NREGS defaults, dump FSM state enum (IDLE, SEND), REG_ZERO constant.
- Natural sub-module regfile_dump_fsm: handshake, index counter, Lo/Hi capture, error pulse. Reads the array through one internal read port.
- Top holds the storage array, NRD read muxes and bypass logic.

Test Plan:
- Reset, write r8=0x0000_00AA, r4=0x1234_5678, r0=0xFFFF_FFFF -> RdData r8=0xAA, r4=0x12345678, r0=0; pulse Reset -> all reads 0.
- Bypass: WrEn=1, WrAddr=17, WrData=0xDEAD_BEEF, RdAddr0=17 same cycle -> RdData0=0xDEADBEEF before the edge; with BYPASS=0 -> old value 0.
- Full dump, Lo=0, Hi=31, DumpReady=1 -> Valid at t+1, 32 consecutive beats, Addr 0..31, DumpLast only on 31, Busy drops at t+33.
- Backpressure: Lo=4, Hi=8, Ready toggled 1/0 and a write r4=0x55 while beat 4 stalled -> beat 4 holds the old value stably; exactly 5 beats accepted.
- Lo=9, Hi=3 -> DumpErr high one cycle, Busy stays 0. Lo=Hi=8 -> one beat, DumpLast=1.
- Reset asserted at beat 10 of a 0..31 dump -> Valid/Busy drop asynchronously; a new dump after release starts again at DumpLo.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file and its debug dump engine.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREGS_DEF  = 32;
  localparam int REG_ZERO   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: streams registers lo..hi over a valid/ready handshake, one beat per cycle.
// state | meaning
// IDLE  | waiting for a start request; rejects lo > hi with a one-cycle err pulse
// SEND  | presenting a registered beat until the sink accepts it
module regfile_dump_fsm
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] lo,
  input  logic [ADDR_W-1:0] hi,
  input  logic              ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_idx,
  output logic              busy,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              err
);

  dump_state_t       state, state_nxt;
  logic [ADDR_W-1:0] hi_q;
  logic [ADDR_W-1:0] last_idx;
  logic              load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rd_idx    = lo;
    last_idx  = hi;
    case (state)
      IDLE: begin
        if (start && (lo <= hi)) begin
          state_nxt = SEND;
          load      = 1'b1;
        end
      end
      SEND: begin
        // rd_idx only matters on a non-last accept, so the wrap past NREGS-1 is harmless
        rd_idx   = addr + ADDR_W'(1);
        last_idx = hi_q;
        if (ready) begin
          if (last) state_nxt = IDLE;
          else      load      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      addr <= '0;
      data <= '0;
      last <= 1'b0;
      err  <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && (lo > hi);
      if (load) begin
        addr <= rd_idx;
        data <= rd_data;
        last <= (rd_idx == last_idx);
        if (state == IDLE) hi_q <= hi;
      end else if ((state == SEND) && ready && last) begin
        last <= 1'b0;
      end
    end
  end

  assign busy  = (state == SEND);
  assign valid = (state == SEND);

endmodule

// File: rtl/mips_regfile_dbg.sv
// Parametrised register file with NRD combinational read ports, optional write bypass
// and a dump engine that streams a register range out over valid/ready.
module mips_regfile_dbg
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  ClockIn,
  input  logic                  Reset,
  input  logic [NRD*ADDR_W-1:0] RdAddr,
  output logic [NRD*DATA_W-1:0] RdData,
  input  logic                  WrEn,
  input  logic [ADDR_W-1:0]     WrAddr,
  input  logic [DATA_W-1:0]     WrData,
  input  logic                  DumpStart,
  input  logic [ADDR_W-1:0]     DumpLo,
  input  logic [ADDR_W-1:0]     DumpHi,
  output logic                  DumpBusy,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic [ADDR_W-1:0]     DumpAddr,
  output logic [DATA_W-1:0]     DumpData,
  output logic                  DumpLast,
  output logic                  DumpErr
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              wr_ok;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_rd;

  assign wr_ok = WrEn && (WrAddr != ADDR_W'(REG_ZERO));

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[WrAddr] <= WrData;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = RdAddr[g*ADDR_W +: ADDR_W];
    assign RdData[g*DATA_W +: DATA_W] =
      (ra == ADDR_W'(REG_ZERO))                ? '0     :
      ((BYPASS != 0) && wr_ok && (ra == WrAddr)) ? WrData :
                                                   regs[ra];
  end

  // The dump port always forwards: a beat captures the value as it stands after its load edge.
  assign dump_rd = (dump_idx == ADDR_W'(REG_ZERO))   ? '0     :
                   (wr_ok && (dump_idx == WrAddr)) ? WrData :
                                                     regs[dump_idx];

  regfile_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk     (ClockIn),
    .rst_n   (Reset),
    .start   (DumpStart),
    .lo      (DumpLo),
    .hi      (DumpHi),
    .ready   (DumpReady),
    .rd_data (dump_rd),
    .rd_idx  (dump_idx),
    .busy    (DumpBusy),
    .valid   (DumpValid),
    .addr    (DumpAddr),
    .data    (DumpData),
    .last    (DumpLast),
    .err     (DumpErr)
  );

endmodule

// File: tb/tb_mips_regfile_dbg.sv
// Bench for mips_regfile_dbg: array reference model, dump beats checked by a scoreboard monitor.
module tb_mips_regfile_dbg;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 2;

  logic           ClockIn = 1'b0;
  logic           Reset = 1'b0;
  logic [NP*AW-1:0] RdAddr = '0;
  logic [NP*DW-1:0] RdData, RdData_nb;
  logic           WrEn = 1'b0;
  logic [AW-1:0]  WrAddr = '0;
  logic [DW-1:0]  WrData = '0;
  logic           DumpStart = 1'b0;
  logic [AW-1:0]  DumpLo = '0, DumpHi = '0;
  logic           DumpReady = 1'b0;
  logic           DumpBusy, DumpValid, DumpLast, DumpErr;
  logic [AW-1:0]  DumpAddr;
  logic [DW-1:0]  DumpData;
  logic           nb_busy, nb_valid, nb_last, nb_err;
  logic [AW-1:0]  nb_addr;
  logic [DW-1:0]  nb_data;

  mips_regfile_dbg #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(1)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .RdAddr(RdAddr), .RdData(RdData),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .DumpStart(DumpStart), .DumpLo(DumpLo), .DumpHi(DumpHi),
    .DumpBusy(DumpBusy), .DumpValid(DumpValid), .DumpReady(DumpReady),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpLast(DumpLast), .DumpErr(DumpErr)
  );

  // Second instance without bypass shares all inputs; its dump engine is never started.
  mips_regfile_dbg #(.DATA_W(DW), .NREGS(NR), .NRD(NP), .BYPASS(0)) dut_nb (
    .ClockIn(ClockIn), .Reset(Reset), .RdAddr(RdAddr), .RdData(RdData_nb),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .DumpStart(1'b0), .DumpLo(DumpLo), .DumpHi(DumpHi),
    .DumpBusy(nb_busy), .DumpValid(nb_valid), .DumpReady(1'b1),
    .DumpAddr(nb_addr), .DumpData(nb_data), .DumpLast(nb_last), .DumpErr(nb_err)
  );

  always #5 ClockIn = ~ClockIn;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         exp_b;
  beat_t         held;
  logic          stall_q = 1'b0;
  logic [DW-1:0] mdl [NR];
  int            total = 0;
  int            bad = 0;
  int            beats_seen = 0;
  int            ready_mode = 0;
  int            cyc;
  int            b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink behaviour: 0 stalled, 1 always ready, 2 random, 3 toggling.
  always @(posedge ClockIn) begin
    #1;
    case (ready_mode)
      0:       DumpReady = 1'b0;
      1:       DumpReady = 1'b1;
      2:       DumpReady = 1'($urandom_range(0, 1));
      default: DumpReady = ~DumpReady;
    endcase
  end

  always @(negedge ClockIn) begin
    if (DumpValid && stall_q) begin
      check("stall_addr", DumpAddr, held.addr);
      check("stall_data", DumpData, held.data);
      check("stall_last", DumpLast, held.last);
    end
    if (DumpValid && DumpReady) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got addr %0d data %0h, no beat expected", DumpAddr, DumpData);
      end else begin
        exp_b = exp_q.pop_front();
        check("beat_addr", DumpAddr, exp_b.addr);
        check("beat_data", DumpData, exp_b.data);
        check("beat_last", DumpLast, exp_b.last);
      end
    end
    stall_q = DumpValid && !DumpReady;
    held    = {DumpAddr, DumpData, DumpLast};
  end

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    tick();
    WrEn = 1'b0;
    if (a != 0) mdl[a] = d;
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return (a == 0) ? '0 : mdl[a];
  endfunction

  task automatic check_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    RdAddr = {a1, a0};
    #1;
    check("rd0", RdData[DW-1:0], ref_rd(a0));
    check("rd1", RdData[2*DW-1:DW], ref_rd(a1));
    check("rd0_nobyp", RdData_nb[DW-1:0], ref_rd(a0));
  endtask

  task automatic start_dump(input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                            input logic wen, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    DumpStart = 1'b1; DumpLo = lo; DumpHi = hi;
    WrEn = wen; WrAddr = wa; WrData = wd;
    if (wen && wa != 0) mdl[wa] = wd;
    if (lo <= hi)
      for (int i = int'(lo); i <= int'(hi); i++)
        exp_q.push_back('{addr: AW'(i), data: mdl[i], last: (i == int'(hi))});
    tick();
    DumpStart = 1'b0; WrEn = 1'b0;
    if (lo <= hi) begin
      check("start_valid", DumpValid, 1);
      check("start_busy", DumpBusy, 1);
    end else begin
      check("err_pulse", DumpErr, 1);
      check("err_busy", DumpBusy, 0);
      tick();
      check("err_clear", DumpErr, 0);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (DumpBusy && n < budget) begin
      tick();
      n++;
    end
    if (DumpBusy) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #1;
    check("rst_busy", DumpBusy, 0);
    check("rst_valid", DumpValid, 0);
    check("rst_err", DumpErr, 0);
    check("rst_addr", DumpAddr, 0);
    check("rst_data", DumpData, 0);
    repeat (2) @(negedge ClockIn);
    Reset = 1'b1;
    tick();

    do_write(5'd8, 32'h0000_00AA);
    do_write(5'd4, 32'h1234_5678);
    do_write(5'd0, 32'hFFFF_FFFF);
    check_reads(5'd8, 5'd4);
    check_reads(5'd0, 5'd8);

    WrEn = 1'b1; WrAddr = 5'd17; WrData = 32'hDEAD_BEEF; RdAddr = {5'd4, 5'd17};
    #1;
    check("bypass_on", RdData[DW-1:0], 32'hDEAD_BEEF);
    check("bypass_off", RdData_nb[DW-1:0], 32'h0);
    check("bypass_other", RdData[2*DW-1:DW], 32'h1234_5678);
    tick();
    WrEn = 1'b0;
    mdl[17] = 32'hDEAD_BEEF;
    WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFF_FFFF; RdAddr = {5'd0, 5'd0};
    #1;
    check("bypass_r0", RdData[DW-1:0], 32'h0);
    tick();
    WrEn = 1'b0;
    check_reads(5'd17, 5'd0);

    for (int i = 1; i < NR; i += 3) do_write(AW'(i), $urandom());
    ready_mode = 1;
    tick();
    b0 = beats_seen;
    start_dump(5'd0, 5'd31, 1'b0, 5'd0, 32'h0);
    wait_done(100, cyc);
    check("full_cycles", cyc, 32);
    check("full_beats", beats_seen - b0, 32);
    check("full_q_empty", exp_q.size(), 0);

    ready_mode = 0;
    tick();
    b0 = beats_seen;
    start_dump(5'd4, 5'd8, 1'b0, 5'd0, 32'h0);
    tick();
    do_write(5'd4, 32'h55);
    DumpStart = 1'b1; DumpLo = 5'd0; DumpHi = 5'd1;
    tick();
    DumpStart = 1'b0;
    check("send_start_noerr", DumpErr, 0);
    check("stalled_addr", DumpAddr, 4);
    ready_mode = 3;
    wait_done(100, cyc);
    check("bp_beats", beats_seen - b0, 5);
    check("bp_q_empty", exp_q.size(), 0);

    ready_mode = 1;
    tick();
    start_dump(5'd9, 5'd3, 1'b0, 5'd0, 32'h0);
    start_dump(5'd8, 5'd8, 1'b0, 5'd0, 32'h0);
    check("single_last", DumpLast, 1);
    wait_done(10, cyc);
    check("single_cycles", cyc, 1);
    start_dump(5'd12, 5'd14, 1'b1, 5'd12, 32'hCAFE_0012);
    wait_done(20, cyc);
    check("byp_dump_q_empty", exp_q.size(), 0);

    repeat (25) begin
      ready_mode = 2;
      repeat (3) do_write(AW'($urandom_range(0, NR - 1)), $urandom());
      check_reads(AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
      start_dump(AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom());
      wait_done(300, cyc);
    end
    check("rand_q_empty", exp_q.size(), 0);

    ready_mode = 1;
    tick();
    b0 = beats_seen;
    start_dump(5'd0, 5'd31, 1'b0, 5'd0, 32'h0);
    cyc = 0;
    while ((beats_seen - b0) < 10 && cyc < 100) begin
      @(negedge ClockIn);
      cyc++;
    end
    check("mid_reached_beat10", beats_seen - b0, 10);
    #1 Reset = 1'b0;
    #1;
    check("mid_rst_valid", DumpValid, 0);
    check("mid_rst_busy", DumpBusy, 0);
    check("mid_rst_last", DumpLast, 0);
    check("mid_rst_addr", DumpAddr, 0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    for (int i = 0; i < NR / 2; i++) check_reads(AW'(i), AW'(i + NR / 2));
    @(negedge ClockIn);
    Reset = 1'b1;
    tick();
    do_write(5'd5, 32'h0505_0505);
    do_write(5'd7, 32'h0707_0707);
    ready_mode = 2;
    start_dump(5'd5, 5'd7, 1'b0, 5'd0, 32'h0);
    wait_done(100, cyc);
    check("post_rst_q_empty", exp_q.size(), 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
